// File: rtl/cdlcm_frame_scheduler.sv
`timescale 1ns/1ps
// cdlcm_frame_scheduler
// Streams one image out of the frame RAM into the CDLCM pipeline in raster
// order with v_sync/h_sync framing and programmable row blanking. After the
// last row, it waits for the pipeline's result frame before reporting done.
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_start, i_abort         frame start request / abort current frame
//   i_hblank                 requested row blanking, sampled at accepted start
//   o_rd_en, o_rd_addr       frame RAM read port (raster order)
//   i_rd_data                RAM data, valid one cycle after o_rd_en
//   o_v_sync, o_h_sync,
//   o_img_data               pixel stream to the CDLCM input
//   i_res_v_sync,
//   i_res_h_sync             CDLCM result stream framing
//   o_busy, o_done,
//   o_timeout                frame status
module cdlcm_frame_scheduler #(
  parameter int P_DATA_WIDTH   = 20,
  parameter int P_IMAGE_WIDTH  = 256,
  parameter int P_IMAGE_HEIGHT = 256,
  parameter int P_HBLANK_MIN   = 32,
  parameter int P_VPRE         = 16,
  parameter int P_VPOST        = 64,
  parameter int P_TIMEOUT      = 1 << 20
) (
  input  logic                                                  i_clk,
  input  logic                                                  i_rst,
  input  logic                                                  i_start,
  input  logic                                                  i_abort,
  input  logic [15:0]                                           i_hblank,
  output logic                                                  o_rd_en,
  output logic [$clog2(P_IMAGE_WIDTH*P_IMAGE_HEIGHT)-1:0]       o_rd_addr,
  input  logic [P_DATA_WIDTH-1:0]                               i_rd_data,
  output logic                                                  o_v_sync,
  output logic                                                  o_h_sync,
  output logic [P_DATA_WIDTH-1:0]                               o_img_data,
  input  logic                                                  i_res_v_sync,
  input  logic                                                  i_res_h_sync,
  output logic                                                  o_busy,
  output logic                                                  o_done,
  output logic                                                  o_timeout
);

  localparam int LP_PIX    = P_IMAGE_WIDTH * P_IMAGE_HEIGHT;
  localparam int LP_ADDR_W = $clog2(LP_PIX);
  localparam int LP_ROW_W  = $clog2(P_IMAGE_HEIGHT + 1);
  localparam int LP_COL_W  = $clog2(P_IMAGE_WIDTH + 1);
  localparam int LP_DRN_W  = $clog2(P_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VPRE   = 3'd1;
  localparam logic [2:0] S_LINE   = 3'd2;
  localparam logic [2:0] S_HBLANK = 3'd3;
  localparam logic [2:0] S_VPOST  = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  logic [2:0]           r_state;
  logic [15:0]          r_hblank;
  logic [15:0]          r_cnt;        // shared by VPRE, HBLANK and VPOST
  logic [LP_COL_W-1:0]  r_col;
  logic [LP_ROW_W-1:0]  r_row;
  logic [LP_ROW_W-1:0]  r_res_rows;   // result rows seen since start
  logic [LP_DRN_W-1:0]  r_drain;
  logic [LP_ADDR_W-1:0] r_rd_addr;
  logic                 r_res_h_prev;
  logic                 r_v_sync;
  logic                 r_h_sync;
  logic                 r_done;
  logic                 r_timeout;

  logic                 w_start_ok;
  logic                 w_res_rise;
  logic                 w_drain_ok;
  logic                 w_last_addr;
  logic [15:0]          w_hblank_eff;

  // A start landing on the done cycle is dropped, as is one paired with abort.
  assign w_start_ok   = (r_state == S_IDLE) && i_start && !i_abort && !r_done;
  assign w_res_rise   = i_res_h_sync && !r_res_h_prev;
  assign w_drain_ok   = (r_res_rows == LP_ROW_W'(P_IMAGE_HEIGHT)) && !i_res_v_sync;
  assign w_last_addr  = (r_rd_addr == LP_ADDR_W'(LP_PIX - 1));
  assign w_hblank_eff = (i_hblank > 16'(P_HBLANK_MIN)) ? i_hblank : 16'(P_HBLANK_MIN);

  assign o_rd_en    = (r_state == S_LINE);
  assign o_rd_addr  = r_rd_addr;
  assign o_v_sync   = r_v_sync;
  assign o_h_sync   = r_h_sync;
  // RAM data arrives one cycle after the read, which is when h_sync is high.
  assign o_img_data = r_h_sync ? i_rd_data : '0;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_timeout  = r_timeout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_hblank     <= '0;
      r_cnt        <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_res_rows   <= '0;
      r_drain      <= '0;
      r_rd_addr    <= '0;
      r_res_h_prev <= 1'b0;
      r_v_sync     <= 1'b0;
      r_h_sync     <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_res_h_prev <= i_res_h_sync;
      // Result rows are counted for the whole frame so early results count.
      if (r_state != S_IDLE && w_res_rise) begin
        r_res_rows <= r_res_rows + 1'b1;
      end

      if (r_state != S_IDLE && i_abort) begin
        r_state  <= S_IDLE;
        r_v_sync <= 1'b0;
        r_h_sync <= 1'b0;
      end else begin
        r_h_sync <= (r_state == S_LINE);
        r_v_sync <= (r_state != S_IDLE) && (r_state != S_DRAIN);
        case (r_state)
          S_IDLE: begin
            if (w_start_ok) begin
              r_state    <= S_VPRE;
              r_hblank   <= w_hblank_eff;
              r_timeout  <= 1'b0;
              r_rd_addr  <= '0;
              r_cnt      <= '0;
              r_col      <= '0;
              r_row      <= '0;
              r_res_rows <= '0;
              r_drain    <= '0;
            end
          end
          S_VPRE: begin
            if (r_cnt == 16'(P_VPRE - 1)) begin
              r_cnt   <= '0;
              r_state <= S_LINE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_LINE: begin
            // Address saturates on the final pixel instead of wrapping past the image.
            if (!w_last_addr) begin
              r_rd_addr <= r_rd_addr + 1'b1;
            end
            if (r_col == LP_COL_W'(P_IMAGE_WIDTH - 1)) begin
              r_col   <= '0;
              r_state <= S_HBLANK;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
          S_HBLANK: begin
            if (r_cnt == r_hblank - 16'd1) begin
              r_cnt <= '0;
              if (r_row == LP_ROW_W'(P_IMAGE_HEIGHT - 1)) begin
                r_row   <= '0;
                r_state <= S_VPOST;
              end else begin
                r_row   <= r_row + 1'b1;
                r_state <= S_LINE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_VPOST: begin
            if (r_cnt == 16'(P_VPOST - 1)) begin
              r_cnt   <= '0;
              r_drain <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DRAIN: begin
            // Completion wins over timeout when both happen on the same cycle.
            if (w_drain_ok) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else if (r_drain == LP_DRN_W'(P_TIMEOUT - 1)) begin
              r_state   <= S_IDLE;
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
            end else begin
              r_drain <= r_drain + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdlcm_frame_scheduler.sv
`timescale 1ns/1ps
module tb_cdlcm_frame_scheduler;
  localparam int W = 8, H = 4, DW = 20, HMIN = 32, VPRE = 4, VPOST = 6, TMO = 100;
  localparam int WH = W * H, AW = $clog2(WH);

  logic          clk = 1'b0;
  logic          i_rst, i_start, i_abort, i_res_v_sync, i_res_h_sync;
  logic [15:0]   i_hblank;
  logic          o_rd_en, o_v_sync, o_h_sync, o_busy, o_done, o_timeout;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rd_data, o_img_data;

  always #5 clk = ~clk;

  cdlcm_frame_scheduler #(
    .P_DATA_WIDTH(DW), .P_IMAGE_WIDTH(W), .P_IMAGE_HEIGHT(H), .P_HBLANK_MIN(HMIN),
    .P_VPRE(VPRE), .P_VPOST(VPOST), .P_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_hblank(i_hblank),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_v_sync(o_v_sync), .o_h_sync(o_h_sync), .o_img_data(o_img_data),
    .i_res_v_sync(i_res_v_sync), .i_res_h_sync(i_res_h_sync),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout)
  );

  // Frame RAM with one cycle read latency.
  logic [DW-1:0] ram [WH];
  always @(posedge clk) if (o_rd_en) i_rd_data <= ram[o_rd_addr];

  int n_checks = 0, n_pass = 0, cyc = 0, st_cyc = 0, done_cyc = -1;
  int last_gap = 0, last_run = 0, run_cnt = 0, gap_cnt = 0, hs_total = 0;
  bit prev_obs_rd = 0;
  bit res_h_q[$], res_v_q[$];

  // Reference model: frame timeline as offsets from the accepted start cycle.
  bit m_active, m_prev_rd, m_prev_vst, m_prev_resh, m_done_next, m_timeout;
  int m_s, m_hb, m_n_rd, m_edges, m_prev_addr;
  bit e_busy, e_done, e_to, e_rd, e_v, e_h;
  int e_addr;
  logic [DW-1:0] e_img;

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else begin
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      if (n_checks - n_pass >= 40) begin summary(); $finish; end
    end
  endtask

  function automatic int d0(input int hb);  // first DRAIN cycle offset
    return 1 + VPRE + H * (W + hb) + VPOST;
  endfunction

  function automatic bit in_line(input int d, input int hb);
    int x;
    x = d - 1 - VPRE;
    return (x >= 0) && (x < H * (W + hb)) && ((x % (W + hb)) < W);
  endfunction

  task automatic model_reset();
    m_active = 0; m_prev_rd = 0; m_prev_vst = 0; m_prev_resh = 0; m_done_next = 0;
    m_timeout = 0; m_s = 0; m_hb = 0; m_n_rd = 0; m_edges = 0; m_prev_addr = 0;
  endtask

  task automatic model_expect();
    e_busy = m_active; e_done = m_done_next; e_to = m_timeout;
    e_addr = (m_n_rd > WH - 1) ? WH - 1 : m_n_rd;
    e_rd   = m_active && in_line(cyc - m_s, m_hb);
    e_h    = m_prev_rd;
    e_v    = m_prev_vst;
    e_img  = e_h ? ram[m_prev_addr] : '0;
  endtask

  task automatic model_update();
    int d, dd;
    bit vst, rdk, nd, complete;
    if (i_rst) begin model_reset(); return; end
    d = cyc - m_s; dd = d0(m_hb); vst = 0; rdk = e_rd; nd = 0;
    if (m_active) begin
      vst = (d <= dd - 1);
      complete = (m_edges == H) && !i_res_v_sync;
      if (i_abort) begin
        m_active = 0; vst = 0; rdk = 0;
      end else if (d >= dd && (complete || (d - dd == TMO - 1))) begin
        if (!complete) m_timeout = 1;
        m_active = 0; nd = 1;
      end
      if (i_res_h_sync && !m_prev_resh) m_edges++;
    end else if (i_start && !i_abort && !e_done) begin
      m_active = 1; m_s = cyc; m_hb = (i_hblank > HMIN) ? int'(i_hblank) : HMIN;
      m_n_rd = 0; m_timeout = 0; m_edges = 0;
    end
    if (rdk) m_n_rd++;
    m_prev_rd = rdk; m_prev_vst = vst; m_prev_addr = e_addr;
    m_prev_resh = i_res_h_sync; m_done_next = nd;
  endtask

  // One clock: advance the model with this cycle's inputs, then compare.
  task automatic step();
    model_update();
    @(posedge clk); #1;
    cyc++;
    i_start = 0; i_abort = 0;
    if (res_h_q.size() > 0) begin
      i_res_h_sync = res_h_q.pop_front(); i_res_v_sync = res_v_q.pop_front();
    end else begin
      i_res_h_sync = 0; i_res_v_sync = 0;
    end
    model_expect();
    check("flags", {o_busy, o_done, o_timeout, o_rd_en, o_v_sync, o_h_sync},
          {e_busy, e_done, e_to, e_rd, e_v, e_h});
    check("rd_addr", o_rd_addr, e_addr);
    check("img_data", o_img_data, e_img);
    if (o_rd_en) begin
      if (!prev_obs_rd) last_gap = gap_cnt;
      run_cnt++; gap_cnt = 0;
    end else begin
      if (prev_obs_rd) last_run = run_cnt;
      run_cnt = 0; gap_cnt++;
    end
    prev_obs_rd = o_rd_en;
    if (o_h_sync) hs_total++;
    if (o_done) done_cyc = cyc;
  endtask

  task automatic queue_results(input int delay);
    repeat (delay) begin res_h_q.push_back(0); res_v_q.push_back(0); end
    res_h_q.push_back(0); res_v_q.push_back(1);
    for (int b = 0; b < H; b++) begin
      repeat ($urandom_range(1, 6)) begin res_h_q.push_back(1); res_v_q.push_back(1); end
      repeat ($urandom_range(1, 4)) begin res_h_q.push_back(0); res_v_q.push_back(1); end
    end
    res_h_q.push_back(0); res_v_q.push_back(0);
  endtask

  task automatic start_frame(input int hb, input bit results, input int delay);
    res_h_q.delete(); res_v_q.delete();
    i_hblank = 16'(hb); i_start = 1; st_cyc = cyc; hs_total = 0; done_cyc = -1;
    if (results) queue_results(delay);
    step();
  endtask

  task automatic wait_done(input int maxc, input bit busy_starts, input int abort_at);
    int n;
    n = 0;
    while (m_active && n < maxc) begin
      if (busy_starts && $urandom_range(0, 15) == 0) i_start = 1;
      if (cyc - st_cyc == abort_at) i_abort = 1;
      step(); n++;
    end
    check("frame_end_busy", o_busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got running, want finished");
    summary();
    $fatal(1);
  end

  initial begin
    int hb, kind;
    i_rst = 1; i_start = 0; i_abort = 0; i_hblank = 0; i_res_h_sync = 0; i_res_v_sync = 0;
    for (int i = 0; i < WH; i++) ram[i] = DW'($urandom);
    model_reset();
    repeat (3) step();
    check("reset_flags", {o_busy, o_done, o_timeout, o_rd_en, o_v_sync, o_h_sync}, 0);
    check("reset_addr", o_rd_addr, 0);
    check("reset_img", o_img_data, 0);
    i_rst = 0; step();

    // hblank 40, result frame arrives early: done one cycle after first DRAIN cycle
    start_frame(40, 1, 10);
    wait_done(2000, 0, -1);
    check("A_done_offset", done_cyc - st_cyc, 204);
    check("A_hsync_total", hs_total, 32);
    check("A_row_len", last_run, 8);
    check("A_gap_len", last_gap, 40);
    check("A_done_busy", {o_done, o_busy}, 2'b10);
    i_start = 1; step();                      // start on the done cycle is dropped
    check("start_on_done_busy", o_busy, 0);

    // hblank 5 clamps to 32; no results so the drain times out
    start_frame(5, 0, 0);
    wait_done(2000, 0, -1);
    check("B_done_offset", done_cyc - st_cyc, 271);
    check("B_gap_len", last_gap, 32);
    check("B_timeout", o_timeout, 1);
    repeat (3) step();
    check("B_timeout_sticky", o_timeout, 1);

    // new start clears the timeout flag; stray starts while busy
    start_frame(33, 1, 120);
    check("C_timeout_cleared", o_timeout, 0);
    wait_done(2000, 1, -1);
    check("C_gap_len", last_gap, 33);

    // abort at row 2, column 3
    step();
    start_frame(40, 0, 0);
    wait_done(2000, 0, 1 + VPRE + 2 * (W + 40) + 3);
    check("abort_outputs", {o_v_sync, o_h_sync, o_rd_en, o_busy}, 0);
    check("abort_addr_hold", o_rd_addr, 19);
    repeat (20) step();
    check("abort_no_done", done_cyc, -1);
    start_frame(40, 1, 30);
    check("restart_addr", o_rd_addr, 0);
    wait_done(2000, 0, -1);
    step();
    i_abort = 1; i_start = 1; step();         // abort beats start while idle
    check("abort_start_idle", o_busy, 0);

    // randomized frames
    for (int f = 0; f < 5; f++) begin
      hb = $urandom_range(0, 60);
      kind = $urandom_range(0, 4);
      start_frame(hb, kind != 0, $urandom_range(0, 250));
      wait_done(2000, 1, (kind == 4) ? int'($urandom_range(1, 250)) : -1);
      repeat ($urandom_range(1, 4)) step();
    end

    // start while busy, then asynchronous reset mid-LINE
    start_frame(32, 1, 5);
    for (int n = 0; n < 50 && (cyc - st_cyc) < 1 + VPRE + 3; n++) begin
      if (cyc - st_cyc == 2) i_start = 1;
      step();
    end
    check("pre_reset_addr", o_rd_addr, 3);
    #2 i_rst = 1;
    #1;
    check("async_reset_flags", {o_busy, o_done, o_timeout, o_rd_en, o_v_sync, o_h_sync}, 0);
    check("async_reset_addr", o_rd_addr, 0);
    check("async_reset_img", o_img_data, 0);
    step(); step();
    i_rst = 0; step();
    check("post_reset_busy", o_busy, 0);

    summary();
    $finish;
  end
endmodule
